// File: rtl/lu4_timer_pkg.sv
// Shared definitions for the LU4 timer sequencer: FSM encoding and slice-select levels.
package lu4_timer_pkg;
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_RUN  = 2'd2;
    localparam state_t ST_HOLD = 2'd3;

    localparam logic SD_LOAD  = 1'b1;
    localparam logic SD_COUNT = 1'b0;
endpackage

// File: rtl/lu4_timer_ctrl_if.sv
// Bus between the timer sequencer and the external LU4 counter slices.
interface lu4_timer_ctrl_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] cnt_d;
    logic             cnt_sd;
    logic             cnt_sp;
    logic             cnt_ci;
    logic             cnt_co;

    modport master (output cnt_d, output cnt_sd, output cnt_sp, output cnt_ci, input cnt_co);
    modport slave  (input cnt_d, input cnt_sd, input cnt_sp, input cnt_ci, output cnt_co);
endinterface

// File: rtl/lu4_prescaler.sv
// Free-running divider: tick is high while the count equals limit, and the count wraps there.
module lu4_prescaler #(
    parameter int PRE_W = 8
) (
    input  logic             CK,
    input  logic             CD,
    input  logic             clr,
    input  logic             en,
    input  logic [PRE_W-1:0] limit,
    output logic             tick
);
    logic [PRE_W-1:0] count;

    assign tick = (count == limit);

    always_ff @(posedge CK or posedge CD) begin
        if (CD) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end
endmodule

// File: rtl/lu4_timer_ctrl.sv
// Sequencer for an external chain of LU4 counter slices: preload, prescaled counting,
// pause/hold, one-shot or periodic terminal handling.
module lu4_timer_ctrl
    import lu4_timer_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int PRE_W = 8
) (
    input  logic               CK,
    input  logic               CD,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic [WIDTH-1:0]   period,
    input  logic [PRE_W-1:0]   prescale,
    input  logic               auto_reload,
    lu4_timer_ctrl_if.master   cnt,
    output logic               busy,
    output logic               expire,
    output logic               cfg_err
);
    state_t           state, state_nxt;
    logic [WIDTH-1:0] period_l;
    logic [PRE_W-1:0] prescale_l;
    logic             reload_l;
    logic             term_pend, term_pend_nxt;
    logic             expire_nxt, cfg_err_nxt;
    logic             tick, terminal, accept;

    lu4_prescaler #(.PRE_W(PRE_W)) u_prescaler (
        .CK    (CK),
        .CD    (CD),
        .clr   (state == ST_LOAD),
        .en    (state == ST_RUN),
        .limit (prescale_l),
        .tick  (tick)
    );

    // Slices count up from -P so the carry-out marks the P-th tick.
    assign cnt.cnt_d = '0 - period_l;
    assign busy      = (state != ST_IDLE);
    assign terminal  = (state == ST_RUN) && cnt.cnt_co;
    assign accept    = (state == ST_IDLE) && start && !stop && (period != '0);

    always_comb begin
        cnt.cnt_sd = SD_COUNT;
        cnt.cnt_sp = 1'b0;
        cnt.cnt_ci = 1'b0;
        case (state)
            ST_LOAD: begin
                cnt.cnt_sd = SD_LOAD;
                cnt.cnt_sp = 1'b1;
            end
            ST_RUN: begin
                cnt.cnt_sp = 1'b1;
                cnt.cnt_ci = tick;
                if (cnt.cnt_co && reload_l) cnt.cnt_sd = SD_LOAD;
            end
            default: ;
        endcase
    end

    // A terminal seen in the same cycle as pause is remembered and reported on resume.
    always_comb begin
        state_nxt     = state;
        term_pend_nxt = term_pend;
        expire_nxt    = 1'b0;
        cfg_err_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                term_pend_nxt = 1'b0;
                if (accept) begin
                    state_nxt = ST_LOAD;
                end else if (start && !stop) begin
                    cfg_err_nxt = 1'b1;
                end
            end
            ST_LOAD: begin
                state_nxt = stop ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (pause) begin
                    state_nxt     = ST_HOLD;
                    term_pend_nxt = terminal;
                end else if (terminal) begin
                    expire_nxt = 1'b1;
                    if (!reload_l) state_nxt = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (stop) begin
                    state_nxt     = ST_IDLE;
                    term_pend_nxt = 1'b0;
                end else if (!pause) begin
                    state_nxt     = ST_RUN;
                    term_pend_nxt = 1'b0;
                    if (term_pend) begin
                        expire_nxt = 1'b1;
                        if (!reload_l) state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CK or posedge CD) begin
        if (CD) begin
            state      <= ST_IDLE;
            term_pend  <= 1'b0;
            expire     <= 1'b0;
            cfg_err    <= 1'b0;
            period_l   <= '0;
            prescale_l <= '0;
            reload_l   <= 1'b0;
        end else begin
            state     <= state_nxt;
            term_pend <= term_pend_nxt;
            expire    <= expire_nxt;
            cfg_err   <= cfg_err_nxt;
            if (accept) begin
                period_l   <= period;
                prescale_l <= prescale;
                reload_l   <= auto_reload;
            end
        end
    end
endmodule

// File: tb/tb_lu4_timer_ctrl.sv
// Bench for lu4_timer_ctrl with a behavioural model of the external counter slices.
module tb_lu4_timer_ctrl;
    import lu4_timer_pkg::*;

    localparam int WIDTH = 8;
    localparam int PRE_W = 8;

    logic             CK = 1'b0;
    logic             CD = 1'b1;
    logic             start = 1'b0, stop = 1'b0, pause = 1'b0, auto_reload = 1'b0;
    logic [WIDTH-1:0] period = '0;
    logic [PRE_W-1:0] prescale = '0;
    logic             busy, expire, cfg_err;
    logic [WIDTH-1:0] q;

    int tests = 0;
    int fails = 0;

    lu4_timer_ctrl_if #(.WIDTH(WIDTH)) bus ();

    lu4_timer_ctrl #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
        .CK          (CK),
        .CD          (CD),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .period      (period),
        .prescale    (prescale),
        .auto_reload (auto_reload),
        .cnt         (bus),
        .busy        (busy),
        .expire      (expire),
        .cfg_err     (cfg_err)
    );

    always #5 CK = ~CK;

    // Counter slice chain: load when sd, else count on ci, carry-out when all-ones with ci.
    always_ff @(posedge CK or posedge CD) begin
        if (CD) q <= '0;
        else if (bus.cnt_sp) q <= bus.cnt_sd ? bus.cnt_d : q + {{(WIDTH-1){1'b0}}, bus.cnt_ci};
    end
    assign bus.cnt_co = (&q) & bus.cnt_ci;

    typedef struct {
        logic [WIDTH-1:0] p;
        logic [PRE_W-1:0] pre;
        logic [WIDTH-1:0] exp_d;
        int               exp_at;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", what, act, exp);
        end
    endtask

    task automatic do_reset();
        start = 1'b0; stop = 1'b0; pause = 1'b0;
        period = '0; prescale = '0; auto_reload = 1'b0;
        CD = 1'b1;
        repeat (2) @(posedge CK);
        @(negedge CK);
        CD = 1'b0;
        @(posedge CK); #1;
    endtask

    // Cycle 0 is the current cycle, whose inputs the caller has already driven.
    task automatic run_until_expire(input int limit, output int at, output logic busy_at,
                                    output logic [WIDTH-1:0] ld_d, output logic ld_sd);
        at = -1; busy_at = 1'bx; ld_d = 'x; ld_sd = 1'bx;
        for (int c = 0; c < limit; c++) begin
            @(negedge CK);
            if (c == 1) begin
                ld_d  = bus.cnt_d;
                ld_sd = bus.cnt_sd;
            end
            if (expire) begin
                at      = c;
                busy_at = busy;
            end
            @(posedge CK); #1;
            start = 1'b0;
            if (at >= 0) break;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int               at, got, n_exp, last, bad, co_at, busy5, seen;
        logic             busy_at, ld_sd, prev_sd;
        logic [WIDTH-1:0] ld_d;
        logic [3:0]       cfg_pat, busy_pat;

        // One-shot vectors: P, prescale, preload, expire cycle = 2 + P*(prescale+1)
        vecs[0] = '{8'd3,   8'd0,   8'hFD, 5};
        vecs[1] = '{8'd1,   8'd0,   8'hFF, 3};
        vecs[2] = '{8'd255, 8'd0,   8'h01, 257};
        vecs[3] = '{8'd4,   8'd3,   8'hFC, 18};
        vecs[4] = '{8'd2,   8'd1,   8'hFE, 6};
        vecs[5] = '{8'd10,  8'd4,   8'hF6, 52};
        vecs[6] = '{8'd1,   8'd255, 8'hFF, 258};

        @(negedge CK);
        check("reset outputs", {busy, expire, cfg_err, bus.cnt_sd, bus.cnt_sp, bus.cnt_ci, bus.cnt_d}, '0);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            check($sformatf("vec%0d idle sp/sd/ci", i), {bus.cnt_sp, bus.cnt_sd, bus.cnt_ci}, 3'b000);
            period = vecs[i].p; prescale = vecs[i].pre; auto_reload = 1'b0; start = 1'b1;
            run_until_expire(600, at, busy_at, ld_d, ld_sd);
            check($sformatf("vec%0d load data", i), ld_d, vecs[i].exp_d);
            check($sformatf("vec%0d load select", i), ld_sd, SD_LOAD);
            check($sformatf("vec%0d expire cycle", i), at, vecs[i].exp_at);
            check($sformatf("vec%0d busy at expire", i), busy_at, 1'b0);
            @(negedge CK);
            check($sformatf("vec%0d expire width", i), expire, 1'b0);
        end

        // Periodic P=3, prescale=2: first expire at 11, then every 9 cycles
        do_reset();
        period = 8'd3; prescale = 8'd2; auto_reload = 1'b1; start = 1'b1;
        n_exp = 0; last = -1; prev_sd = 1'b0;
        for (int c = 0; c < 80 && n_exp < 4; c++) begin
            @(negedge CK);
            if (expire) begin
                check($sformatf("periodic sd at terminal %0d", n_exp), prev_sd, SD_LOAD);
                if (n_exp == 0) check("periodic first expire", c, 11);
                else            check($sformatf("periodic spacing %0d", n_exp), c - last, 9);
                last = c;
                n_exp++;
            end
            prev_sd = bus.cnt_sd;
            @(posedge CK); #1;
            start = 1'b0;
        end
        check("periodic expire count", n_exp, 4);
        check("periodic still busy", busy, 1'b1);
        stop = 1'b1;
        @(posedge CK); #1;
        stop = 1'b0;
        @(negedge CK);
        check("periodic stopped", {busy, expire}, 2'b00);

        // Pause for 7 cycles mid-run: expire moves from 7 to 14, slices frozen in HOLD
        do_reset();
        period = 8'd5; start = 1'b1; got = -1; bad = 0;
        for (int c = 0; c < 30; c++) begin
            pause = (c >= 3 && c <= 9);
            @(negedge CK);
            if (c >= 4 && c <= 10 && (bus.cnt_ci !== 1'b0 || bus.cnt_sp !== 1'b0 || busy !== 1'b1)) bad++;
            if (expire && got < 0) got = c;
            @(posedge CK); #1;
            start = 1'b0;
        end
        pause = 1'b0;
        check("pause expire cycle", got, 14);
        check("pause hold cycles with ci/sp active", bad, 0);

        // Pause coincident with terminal (cycle 3): expire deferred to resume
        do_reset();
        period = 8'd2; start = 1'b1; got = -1; busy_at = 1'bx;
        for (int c = 0; c < 15; c++) begin
            pause = (c >= 3 && c <= 5);
            @(negedge CK);
            if (expire && got < 0) begin got = c; busy_at = busy; end
            @(posedge CK); #1;
            start = 1'b0;
        end
        pause = 1'b0;
        check("deferred terminal expire cycle", got, 7);
        check("deferred terminal busy", busy_at, 1'b0);

        // Stop coincident with carry-out in periodic mode
        do_reset();
        period = 8'd3; auto_reload = 1'b1; start = 1'b1; co_at = 0; busy5 = 1; seen = 0;
        for (int c = 0; c < 10; c++) begin
            stop = (c == 4);
            @(negedge CK);
            if (c == 4) co_at = int'(bus.cnt_co);
            if (c == 5) busy5 = int'(busy);
            if (c >= 5 && expire) seen++;
            @(posedge CK); #1;
            start = 1'b0;
        end
        stop = 1'b0;
        check("stop: carry-out in stop cycle", co_at, 1);
        check("stop: busy next cycle", busy5, 0);
        check("stop: expire pulses", seen, 0);

        // Start while busy is ignored
        do_reset();
        period = 8'd3; start = 1'b1; got = -1; busy5 = 1;
        for (int c = 0; c < 9; c++) begin
            start  = (c == 0 || c == 3);
            period = (c >= 3) ? 8'd10 : 8'd3;
            @(negedge CK);
            if (expire && got < 0) got = c;
            if (c == 7) busy5 = int'(busy);
            @(posedge CK); #1;
        end
        start = 1'b0;
        check("busy start: expire cycle", got, 5);
        check("busy start: idle afterwards", busy5, 0);

        // Start with period 0: one-cycle cfg_err, never busy
        do_reset();
        period = 8'd0; start = 1'b1; cfg_pat = '0; busy_pat = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CK);
            cfg_pat[c]  = cfg_err;
            busy_pat[c] = busy;
            @(posedge CK); #1;
            start = 1'b0;
        end
        check("cfg_err pulse", cfg_pat, 4'b0010);
        check("cfg_err busy", busy_pat, 4'b0000);

        // CD pulsed during HOLD, then a fresh P=1 run
        do_reset();
        period = 8'd5; start = 1'b1;
        for (int c = 0; c < 6; c++) begin
            pause = (c >= 3);
            @(posedge CK); #1;
            start = 1'b0;
        end
        check("hold before CD", {busy, bus.cnt_sp, bus.cnt_ci}, 3'b100);
        #1 CD = 1'b1;
        #1;
        check("async CD outputs", {busy, expire, cfg_err, bus.cnt_sd, bus.cnt_sp, bus.cnt_ci, bus.cnt_d}, '0);
        @(negedge CK);
        CD = 1'b0; pause = 1'b0;
        @(posedge CK); #1;
        check("after CD idle", busy, 1'b0);
        period = 8'd1; prescale = 8'd0; auto_reload = 1'b0; start = 1'b1;
        run_until_expire(20, at, busy_at, ld_d, ld_sd);
        check("post-CD P=1 expire cycle", at, 3);
        check("post-CD P=1 load data", ld_d, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
